// File: rtl/if_prefetch.sv
// if_prefetch
//   Instruction fetch unit feeding the IF/ID register. Owns the fetch PC, issues
//   pipelined requests on a req/gnt/rvalid instruction bus, buffers returned words
//   in a DEPTH-entry FIFO and presents the head entry to IF/ID. An EX-stage branch
//   retargets the fetch PC, empties the FIFO and discards responses still in flight.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   stall_i                   IF/ID holding, head entry is not consumed
//   branch_flag_i/_addr_i     EX redirect strobe and word-aligned target
//   ibus_req_o/_addr_o        fetch request and address (held until granted)
//   ibus_gnt_i                request accepted (qualified with ibus_req_o)
//   ibus_rvalid_i/_rdata_i    in-order read response
//   pc_o/inst_o/inst_valid_o  FIFO head PC, word (0 when empty), non-empty flag
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// FETCH    | normal operation: request while space is reservable, push data
// FLUSH    | after a branch: no requests, drop responses until discard == 0

module if_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  typedef enum logic {ST_FETCH, ST_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]     mem_q [DEPTH];
  logic [31:0]     mem_d [DEPTH];

  logic [CW:0]     occupancy;
  logic [CW-1:0]   inflight;
  logic [CW-1:0]   discard_br;
  logic            grant;
  logic            rv_live;
  logic            push;
  logic            pop;

  // Space is reserved at grant time: FIFO entries plus granted-but-unreturned
  // words may never exceed DEPTH, so a push can never overflow.
  assign occupancy = {1'b0, count_q} + {1'b0, outstanding_q};
  // Only one of outstanding/discard is nonzero at a time; their sum is what the
  // bus still owes us, regardless of state.
  assign inflight  = outstanding_q + discard_q;
  assign grant     = ibus_req_o & ibus_gnt_i;
  // A response with nothing in flight is a bus error and is ignored outright.
  assign rv_live   = ibus_rvalid_i & (inflight != '0);
  assign push      = rv_live & ~branch_flag_i & (state_q == ST_FETCH);
  assign pop       = inst_valid_o & ~stall_i & ~branch_flag_i;
  // The branch cycle never requests, so the grant term is zero in practice;
  // it is kept so the discard count stays correct if that gating ever changes.
  assign discard_br = inflight + CW'(grant) - CW'(rv_live);

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_d = state_q;
    if (branch_flag_i) begin
      state_d = (discard_br != '0) ? ST_FLUSH : ST_FETCH;
    end else if (state_q == ST_FLUSH) begin
      if ((discard_q == '0) || ((discard_q == ONE_C) && rv_live)) state_d = ST_FETCH;
    end
  end

  // ---------------- output logic ----------------
  always_comb begin
    ibus_req_o   = ~rst & (state_q == ST_FETCH) & ~branch_flag_i &
                   (occupancy < {1'b0, DEPTH_C});
    ibus_addr_o  = fetch_pc_q;
    inst_valid_o = (count_q != '0);
    inst_o       = inst_valid_o ? mem_q[rd_ptr_q] : 32'h0;
    pc_o         = pc_q;
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    pc_d          = pc_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];

    if (push) mem_d[wr_ptr_q] = ibus_rdata_i;

    if (branch_flag_i) begin
      fetch_pc_d    = branch_addr_i;
      pc_d          = branch_addr_i;
      count_d       = '0;
      rd_ptr_d      = '0;
      wr_ptr_d      = '0;
      outstanding_d = '0;
      discard_d     = discard_br;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + 32'd4;

      if (state_q == ST_FETCH) begin
        outstanding_d = outstanding_q + CW'(grant) - CW'(rv_live);
      end else if (rv_live) begin
        discard_d = discard_q - ONE_C;
      end

      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        pc_d     = pc_q + 32'd4;
      end

      case ({push, pop})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      pc_q          <= RESET_PC;
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'h0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pc_q          <= pc_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch (DEPTH=4, RESET_PC=0). Inputs change just after
// the rising edge; outputs are checked at the falling edge. A small optional
// responder returns rvalid one cycle after every grant.

module tb_if_prefetch;

  logic        clk;
  logic        rst;
  logic        stall_i;
  logic        branch_flag_i;
  logic [31:0] branch_addr_i;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_gnt_i;
  logic        ibus_rvalid_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  int          checks;
  int          passed;
  int          grant_cnt;
  logic        auto_rsp;
  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] last_gaddr;

  if_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .branch_flag_i (branch_flag_i),
    .branch_addr_i (branch_addr_i),
    .ibus_req_o    (ibus_req_o),
    .ibus_addr_o   (ibus_addr_o),
    .ibus_gnt_i    (ibus_gnt_i),
    .ibus_rvalid_i (ibus_rvalid_i),
    .ibus_rdata_i  (ibus_rdata_i),
    .pc_o          (pc_o),
    .inst_o        (inst_o),
    .inst_valid_o  (inst_valid_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic settle();
    #1;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick();
    #1;
    pend      = ibus_req_o & ibus_gnt_i;
    pend_addr = ibus_addr_o;
    if (pend) begin
      grant_cnt++;
      last_gaddr = ibus_addr_o;
    end
    @(posedge clk);
    #1;
    if (auto_rsp) begin
      ibus_rvalid_i = pend;
      ibus_rdata_i  = pend ? word(pend_addr) : 32'h0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    auto_rsp      = 1'b0;
    rst           = 1'b1;
    stall_i       = 1'b0;
    branch_flag_i = 1'b0;
    branch_addr_i = 32'h0;
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b0;
    ibus_rdata_i  = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_reset();
    auto_rsp = 1'b0; rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0;
    branch_addr_i = 32'h0; ibus_gnt_i = 1'b1; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0;
    tick();
    tick();
    checks++; if (ibus_req_o !== 1'b0) $display("FAIL reset_req got=%0b want=0", ibus_req_o); else passed++;
    checks++; if (ibus_addr_o !== 32'h0) $display("FAIL reset_addr got=%h want=00000000", ibus_addr_o); else passed++;
    checks++; if (pc_o !== 32'h0) $display("FAIL reset_pc got=%h want=00000000", pc_o); else passed++;
    checks++; if (inst_o !== 32'h0) $display("FAIL reset_inst got=%h want=00000000", inst_o); else passed++;
    checks++; if (inst_valid_o !== 1'b0) $display("FAIL reset_valid got=%0b want=0", inst_valid_o); else passed++;
    ibus_gnt_i = 1'b0;
    rst = 1'b0;
    settle();
    checks++; if (ibus_req_o !== 1'b1) $display("FAIL reset_first_req got=%0b want=1", ibus_req_o); else passed++;
  endtask

  task automatic test_stream();
    do_reset();
    ibus_gnt_i = 1'b1;
    auto_rsp   = 1'b1;
    settle();
    checks++; if (ibus_addr_o !== 32'h0) $display("FAIL stream_addr0 got=%h want=00000000", ibus_addr_o); else passed++;
    tick();
    checks++; if (inst_valid_o !== 1'b0) $display("FAIL stream_no_bypass got=%0b want=0", inst_valid_o); else passed++;
    checks++; if (ibus_addr_o !== 32'h4) $display("FAIL stream_addr1 got=%h want=00000004", ibus_addr_o); else passed++;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (inst_valid_o !== 1'b1) $display("FAIL stream_valid[%0d] got=%0b want=1", i, inst_valid_o); else passed++;
      checks++; if (pc_o !== 32'(4*i)) $display("FAIL stream_pc[%0d] got=%h want=%h", i, pc_o, 32'(4*i)); else passed++;
      checks++; if (inst_o !== word(32'(4*i))) $display("FAIL stream_inst[%0d] got=%h want=%h", i, inst_o, word(32'(4*i))); else passed++;
      checks++; if (ibus_addr_o !== 32'(4*(i+2))) $display("FAIL stream_addr[%0d] got=%h want=%h", i, ibus_addr_o, 32'(4*(i+2))); else passed++;
    end
  endtask

  task automatic test_stall();
    do_reset();
    grant_cnt  = 0;
    stall_i    = 1'b1;
    ibus_gnt_i = 1'b1;
    auto_rsp   = 1'b1;
    repeat (8) tick();
    checks++; if (grant_cnt !== 4) $display("FAIL stall_grants got=%0d want=4", grant_cnt); else passed++;
    checks++; if (ibus_req_o !== 1'b0) $display("FAIL stall_req got=%0b want=0", ibus_req_o); else passed++;
    checks++; if (ibus_addr_o !== 32'h10) $display("FAIL stall_addr got=%h want=00000010", ibus_addr_o); else passed++;
    checks++; if (pc_o !== 32'h0 || inst_o !== word(32'h0)) $display("FAIL stall_head got=%h/%h want=00000000/%h", pc_o, inst_o, word(32'h0)); else passed++;
    stall_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 1) begin
        checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h10) $display("FAIL stall_refetch got=%0b/%h want=1/00000010", ibus_req_o, ibus_addr_o); else passed++;
      end
      checks++; if (inst_valid_o !== 1'b1 || pc_o !== 32'(4*i)) $display("FAIL drain_pc[%0d] got=%0b/%h want=1/%h", i, inst_valid_o, pc_o, 32'(4*i)); else passed++;
      checks++; if (inst_o !== word(32'(4*i))) $display("FAIL drain_inst[%0d] got=%h want=%h", i, inst_o, word(32'(4*i))); else passed++;
    end
  endtask

  task automatic test_branch_flush();
    do_reset();
    ibus_gnt_i = 1'b1;
    tick();
    tick();
    ibus_gnt_i    = 1'b0;
    branch_flag_i = 1'b1;
    branch_addr_i = 32'h100;
    settle();
    checks++; if (ibus_req_o !== 1'b0) $display("FAIL br_cycle_req got=%0b want=0", ibus_req_o); else passed++;
    tick();
    branch_flag_i = 1'b0;
    settle();
    checks++; if (ibus_req_o !== 1'b0) $display("FAIL flush1_req got=%0b want=0", ibus_req_o); else passed++;
    checks++; if (pc_o !== 32'h100 || inst_valid_o !== 1'b0) $display("FAIL flush1_head got=%h/%0b want=00000100/0", pc_o, inst_valid_o); else passed++;
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = word(32'h0);
    tick();
    checks++; if (ibus_req_o !== 1'b0 || inst_valid_o !== 1'b0) $display("FAIL flush2 got=%0b/%0b want=0/0", ibus_req_o, inst_valid_o); else passed++;
    ibus_rdata_i = word(32'h4);
    tick();
    ibus_rvalid_i = 1'b0;
    settle();
    checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h100) $display("FAIL flush_done got=%0b/%h want=1/00000100", ibus_req_o, ibus_addr_o); else passed++;
    checks++; if (inst_valid_o !== 1'b0 || pc_o !== 32'h100) $display("FAIL flush_dropped got=%0b/%h want=0/00000100", inst_valid_o, pc_o); else passed++;
    ibus_gnt_i = 1'b1;
    tick();
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = word(32'h100);
    tick();
    ibus_rvalid_i = 1'b0;
    settle();
    checks++; if (inst_valid_o !== 1'b1 || inst_o !== word(32'h100)) $display("FAIL br_target_inst got=%0b/%h want=1/%h", inst_valid_o, inst_o, word(32'h100)); else passed++;
  endtask

  task automatic test_branch_rvalid_gnt();
    do_reset();
    ibus_gnt_i = 1'b1;
    tick();
    tick();
    // outstanding=2; branch arrives with a response and gnt high
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = word(32'h0);
    branch_flag_i = 1'b1;
    branch_addr_i = 32'h200;
    tick();
    branch_flag_i = 1'b0;
    ibus_rvalid_i = 1'b0;
    settle();
    checks++; if (ibus_req_o !== 1'b0) $display("FAIL br_rv_flush_req got=%0b want=0", ibus_req_o); else passed++;
    checks++; if (inst_valid_o !== 1'b0 || pc_o !== 32'h200) $display("FAIL br_rv_dropped got=%0b/%h want=0/00000200", inst_valid_o, pc_o); else passed++;
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = word(32'h4);
    tick();
    ibus_rvalid_i = 1'b0;
    settle();
    checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h200) $display("FAIL br_rv_resume got=%0b/%h want=1/00000200", ibus_req_o, ibus_addr_o); else passed++;
    checks++; if (inst_valid_o !== 1'b0) $display("FAIL br_rv_stale got=%0b want=0", inst_valid_o); else passed++;
    tick();
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = word(32'h200);
    tick();
    ibus_rvalid_i = 1'b0;
    settle();
    checks++; if (inst_o !== word(32'h200) || pc_o !== 32'h200) $display("FAIL br_rv_target got=%h/%h want=%h/00000200", inst_o, pc_o, word(32'h200)); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc;
    do_reset();
    branch_flag_i = 1'b1;
    branch_addr_i = 32'hFFFF_FFF8;
    tick();
    branch_flag_i = 1'b0;
    ibus_gnt_i    = 1'b1;
    auto_rsp      = 1'b1;
    settle();
    checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'hFFFF_FFF8) $display("FAIL wrap_start got=%0b/%h want=1/fffffff8", ibus_req_o, ibus_addr_o); else passed++;
    tick();
    checks++; if (ibus_addr_o !== 32'hFFFF_FFFC) $display("FAIL wrap_addr_fc got=%h want=fffffffc", ibus_addr_o); else passed++;
    tick();
    checks++; if (ibus_addr_o !== 32'h0) $display("FAIL wrap_addr_0 got=%h want=00000000", ibus_addr_o); else passed++;
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 4; i++) begin
      checks++; if (inst_valid_o !== 1'b1 || pc_o !== exp_pc || inst_o !== word(exp_pc)) $display("FAIL wrap_head[%0d] got=%0b/%h/%h want=1/%h/%h", i, inst_valid_o, pc_o, inst_o, exp_pc, word(exp_pc)); else passed++;
      exp_pc = exp_pc + 32'd4;
      tick();
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    ibus_gnt_i = 1'b1;
    tick();
    tick();
    rst           = 1'b1;
    ibus_gnt_i    = 1'b0;
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = word(32'h0);
    settle();
    checks++; if (ibus_req_o !== 1'b0) $display("FAIL midrst_req got=%0b want=0", ibus_req_o); else passed++;
    tick();
    rst           = 1'b0;
    ibus_rvalid_i = 1'b0;
    settle();
    checks++; if (ibus_req_o !== 1'b1 || ibus_addr_o !== 32'h0) $display("FAIL midrst_bus got=%0b/%h want=1/00000000", ibus_req_o, ibus_addr_o); else passed++;
    checks++; if (pc_o !== 32'h0 || inst_o !== 32'h0 || inst_valid_o !== 1'b0) $display("FAIL midrst_out got=%h/%h/%0b want=00000000/00000000/0", pc_o, inst_o, inst_valid_o); else passed++;
    ibus_rvalid_i = 1'b1;
    ibus_rdata_i  = word(32'h4);
    tick();
    ibus_rvalid_i = 1'b0;
    settle();
    checks++; if (inst_valid_o !== 1'b0) $display("FAIL stray_rvalid got=%0b want=0", inst_valid_o); else passed++;
    ibus_gnt_i = 1'b1;
    last_gaddr = 32'hDEAD_BEEF;
    tick();
    checks++; if (last_gaddr !== 32'h0 || ibus_addr_o !== 32'h4) $display("FAIL midrst_first_grant got=%h/%h want=00000000/00000004", last_gaddr, ibus_addr_o); else passed++;
  endtask

  initial begin
    checks = 0; passed = 0; grant_cnt = 0;
    auto_rsp = 1'b0; pend = 1'b0; pend_addr = 32'h0; last_gaddr = 32'h0;
    rst = 1'b1; stall_i = 1'b0; branch_flag_i = 1'b0; branch_addr_i = 32'h0;
    ibus_gnt_i = 1'b0; ibus_rvalid_i = 1'b0; ibus_rdata_i = 32'h0;
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_branch_flush();
    test_branch_rvalid_gnt();
    test_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running want=finished");
    $fatal(1, "watchdog");
  end

endmodule
